deframer: RTL and testbench
===========================

Name: deframer

Overview:
- Receive-side companion to the transmit framer; consumes the byte stream `frame_valid`/`frame_data` and recovers framed content.
- Hunts for the 64-bit preamble, captures the 120-byte header, and forwards the first `payload_len` payload bytes downstream.
- Checks the 32-bit CRC, skips parity bytes, then reports per-frame status and running counters.

Parameters:
- PREAMBLE_BITS, 64, preamble length in bits.
- HEADER_BITS, 960, header length in bits.
- PAYLOAD_BITS, 8416, payload field length in bits (1052 bytes).
- CRC_BITS, 32, CRC length in bits.
- PL_RATE, 0, parity-byte selector: 0→0, 1→288, 2→432, 3→624, other→1152 bytes.
- DATA_WIDTH, 8, stream byte width; only 8 supported.
- GAP_TIMEOUT, 16, max consecutive `in_valid`-low cycles tolerated inside a frame.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input byte qualifier (driven by framer `frame_valid`)
- in_data  in  DATA_WIDTH  input byte
- out_valid  out  1  recovered payload byte valid
- out_data  out  DATA_WIDTH  recovered payload byte
- out_last  out  1  marks the final forwarded payload byte
- hdr_valid  out  1  one-cycle pulse; header fields below are updated
- rx_txfn  out  16  header byte1:byte0 (byte0 = low byte)
- rx_frame_type  out  2  {byte6[7], byte7[0]}
- rx_pl_rate  out  4  byte6[6:3]
- rx_payload_len  out  16  {byte14, byte15}
- frame_ok  out  1  one-cycle pulse; CRC matched
- crc_err  out  1  one-cycle pulse; CRC mismatch
- len_err  out  1  level; `rx_payload_len` > 1052, cleared at next `hdr_valid`
- frame_abort  out  1  one-cycle pulse; gap timeout mid-frame
- ok_cnt  out  16  saturating count of `frame_ok`
- err_cnt  out  16  saturating count of `crc_err` + `frame_abort`

Behaviour:
- Reset: all outputs 0, state HUNT, shift register 0, CRC register 0xFFFFFFFF.
- Only cycles with `in_valid`=1 advance any state or counter.
- HUNT:
  - Shift each byte into a 64-bit register, MSB-first.
  - When the register equals 0x53225B1D0D73DF03 (including the current byte), go to HEADER; byte_cnt=0, CRC=0xFFFFFFFF.
  - Overlapping preambles need no special handling.
- HEADER:
  - Store 120 bytes.
  - On byte 119, go to PAYLOAD.
  - The following cycle: update `rx_*` fields, pulse `hdr_valid`, set `len_err` if len>1052.
  - eff_len = min(len, 1052).
- PAYLOAD:
  - 1052 bytes.
  - Byte index i < eff_len: forward registered (`out_valid`, `out_data`) one cycle after input, and update CRC.
  - CRC algorithm: reflected, poly 0xEDB88320, LSB-first per byte, no final XOR.
  - `out_last` is set with byte eff_len-1.
  - Bytes with i ≥ eff_len are discarded (PRBS fill).
  - eff_len=0: nothing forwarded, CRC stays 0xFFFFFFFF.
- CRC:
  - 4 bytes assembled MSB-first into rx_crc.
  - After byte 3, go to PARITY if parity bytes > 0, else REPORT.
- PARITY: discard N bytes, then go to REPORT.
- REPORT (one cycle, no input consumed):
  - Compare rx_crc against the CRC register.
  - Pulse `frame_ok` or `crc_err`; increment the matching counter (saturate at 0xFFFF).
  - Return to HUNT with the shift register cleared.
- Gap timeout: in any state other than HUNT/REPORT, GAP_TIMEOUT consecutive `in_valid`=0 cycles cause:
  - `frame_abort` pulse and `err_cnt` increment;
  - return to HUNT, shift register cleared;
  - no `out_last` is generated for the partial frame.
- The gap counter resets on every valid byte; shorter gaps are transparent.
- A valid byte arriving in the REPORT cycle is dropped; the upstream framer guarantees ≥1 idle cycle between frames.
- Reset mid-frame: immediate return to reset values; counters cleared.
- Byte counter width 11 bits; `ok_cnt` and `err_cnt` are independent and do not wrap.

Test Plan:
- Framer-format frame, txfn=0x1234, frame_type=2, PL_RATE=0, payload_len=9, payload "123456789", trailing PRBS, CRC bytes 34 0B C6 D9 → `hdr_valid` with rx_txfn=0x1234, rx_frame_type=2, len=9; 9 bytes out, `out_last` on 0x39; `frame_ok`; ok_cnt=1.
- Same frame with CRC byte 3 = 0xD8 → `crc_err`; err_cnt=1; payload still forwarded.
- 10 random bytes, then preamble split by a 3-cycle `in_valid` gap, then frame → sync acquired; `frame_ok`.
- `in_valid` low for 16 cycles at payload byte 500 → `frame_abort`; err_cnt+1; the next full frame is received OK.
- PL_RATE=1, payload_len=0 → no `out_valid`; received CRC 0xFFFFFFFF gives `frame_ok`; 288 parity bytes consumed before REPORT.
- Header len=2000 → `len_err`=1; 1052 bytes forwarded; CRC computed over all 1052.

Source files
------------

// File: rtl/deframer_if.sv
`default_nettype none
// ============================================================================
// Module   : deframer_if
// Brief    : Byte-stream bus (valid/data) between framer, deframer and sink.
// Revision : 1.0 - initial release
// ============================================================================
interface deframer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data);
    modport slave  (input  valid, input  data);
endinterface
`default_nettype wire

// File: rtl/deframer.sv
`default_nettype none
// ============================================================================
// Module   : deframer
// Brief    : Receive deframer - preamble hunt, header capture, payload
//            forwarding, CRC-32 check, parity skip and frame status counters.
// Revision : 1.0 - initial release
// ============================================================================
module deframer #(
    parameter int PREAMBLE_BITS = 64,
    parameter int HEADER_BITS   = 960,
    parameter int PAYLOAD_BITS  = 8416,
    parameter int CRC_BITS      = 32,
    parameter int PL_RATE       = 0,
    parameter int DATA_WIDTH    = 8,
    parameter int GAP_TIMEOUT   = 16
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    deframer_if.slave  in_s,
    deframer_if.master out_s,
    output logic       out_last,
    output logic       hdr_valid,
    output logic [15:0] rx_txfn,
    output logic [1:0]  rx_frame_type,
    output logic [3:0]  rx_pl_rate,
    output logic [15:0] rx_payload_len,
    output logic       frame_ok,
    output logic       crc_err,
    output logic       len_err,
    output logic       frame_abort,
    output logic [15:0] ok_cnt,
    output logic [15:0] err_cnt
);

    localparam int c_hdr_bytes = HEADER_BITS / 8;
    localparam int c_pl_bytes  = PAYLOAD_BITS / 8;
    localparam int c_crc_bytes = CRC_BITS / 8;
    localparam int c_par_bytes = (PL_RATE == 0) ? 0   :
                                 (PL_RATE == 1) ? 288 :
                                 (PL_RATE == 2) ? 432 :
                                 (PL_RATE == 3) ? 624 : 1152;
    localparam int c_gap_w     = $clog2(GAP_TIMEOUT + 1);

    localparam logic [10:0] c_hdr_last  = 11'(c_hdr_bytes - 1);
    localparam logic [10:0] c_pl_last   = 11'(c_pl_bytes - 1);
    localparam logic [10:0] c_pl_max    = 11'(c_pl_bytes);
    localparam logic [15:0] c_len_max   = 16'(c_pl_bytes);
    localparam logic [10:0] c_crc_last  = 11'(c_crc_bytes - 1);
    localparam logic [10:0] c_par_last  = 11'((c_par_bytes > 0) ? c_par_bytes - 1 : 0);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_TIMEOUT - 1);
    localparam logic [PREAMBLE_BITS-1:0] c_preamble = PREAMBLE_BITS'(64'h53225B1D0D73DF03);

    localparam logic [2:0] c_st_hunt    = 3'd0;
    localparam logic [2:0] c_st_header  = 3'd1;
    localparam logic [2:0] c_st_payload = 3'd2;
    localparam logic [2:0] c_st_crc     = 3'd3;
    localparam logic [2:0] c_st_parity  = 3'd4;
    localparam logic [2:0] c_st_report  = 3'd5;

    logic [2:0]               r_state;
    logic [PREAMBLE_BITS-1:0] r_shift;
    logic [10:0]              r_byte_cnt;
    logic [31:0]              r_crc;
    logic [31:0]              r_rx_crc;
    logic [c_gap_w-1:0]       r_gap_cnt;
    logic [7:0]               r_h0, r_h1, r_h14, r_h15;
    logic [4:0]               r_h6;
    logic                     r_h7;
    logic                     r_hdr_pend;
    logic                     r_out_valid;
    logic                     r_out_last;
    logic [DATA_WIDTH-1:0]    r_out_data;
    logic                     r_hdr_valid;
    logic [15:0]              r_rx_txfn;
    logic [1:0]               r_rx_frame_type;
    logic [3:0]               r_rx_pl_rate;
    logic [15:0]              r_rx_payload_len;
    logic                     r_frame_ok;
    logic                     r_crc_err;
    logic                     r_len_err;
    logic                     r_frame_abort;
    logic [15:0]              r_ok_cnt;
    logic [15:0]              r_err_cnt;

    logic [PREAMBLE_BITS-1:0] w_shift_next;
    logic [15:0]              w_len;
    logic [10:0]              w_eff_len;
    logic                     w_fwd;

    // Reflected CRC-32, one byte consumed LSB-first
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign w_shift_next = {r_shift[PREAMBLE_BITS-DATA_WIDTH-1:0], in_s.data};
    assign w_len        = {r_h14, r_h15};
    assign w_eff_len    = (w_len > c_len_max) ? c_pl_max : w_len[10:0];
    assign w_fwd        = (r_byte_cnt < w_eff_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= c_st_hunt;
            r_shift          <= '0;
            r_byte_cnt       <= '0;
            r_crc            <= '1;
            r_rx_crc         <= '0;
            r_gap_cnt        <= '0;
            r_h0             <= '0;
            r_h1             <= '0;
            r_h6             <= '0;
            r_h7             <= 1'b0;
            r_h14            <= '0;
            r_h15            <= '0;
            r_hdr_pend       <= 1'b0;
            r_out_valid      <= 1'b0;
            r_out_last       <= 1'b0;
            r_out_data       <= '0;
            r_hdr_valid      <= 1'b0;
            r_rx_txfn        <= '0;
            r_rx_frame_type  <= '0;
            r_rx_pl_rate     <= '0;
            r_rx_payload_len <= '0;
            r_frame_ok       <= 1'b0;
            r_crc_err        <= 1'b0;
            r_len_err        <= 1'b0;
            r_frame_abort    <= 1'b0;
            r_ok_cnt         <= '0;
            r_err_cnt        <= '0;
        end else begin
            r_hdr_valid   <= 1'b0;
            r_frame_ok    <= 1'b0;
            r_crc_err     <= 1'b0;
            r_frame_abort <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;

            // Header fields publish one cycle after the last header byte
            if (r_hdr_pend) begin
                r_hdr_pend       <= 1'b0;
                r_hdr_valid      <= 1'b1;
                r_rx_txfn        <= {r_h1, r_h0};
                r_rx_frame_type  <= {r_h6[4], r_h7};
                r_rx_pl_rate     <= r_h6[3:0];
                r_rx_payload_len <= w_len;
                r_len_err        <= (w_len > c_len_max);
            end

            case (r_state)
                c_st_hunt: begin
                    if (in_s.valid) begin
                        r_shift <= w_shift_next;
                        if (w_shift_next == c_preamble) begin
                            r_state    <= c_st_header;
                            r_byte_cnt <= '0;
                            r_crc      <= '1;
                            r_gap_cnt  <= '0;
                        end
                    end
                end

                c_st_report: begin
                    if (r_rx_crc == r_crc) begin
                        r_frame_ok <= 1'b1;
                        if (r_ok_cnt != 16'hFFFF) r_ok_cnt <= r_ok_cnt + 16'd1;
                    end else begin
                        r_crc_err <= 1'b1;
                        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                    end
                    r_state <= c_st_hunt;
                    r_shift <= '0;
                end

                default: begin
                    if (!in_s.valid) begin
                        if (r_gap_cnt == c_gap_last) begin
                            r_frame_abort <= 1'b1;
                            if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                            r_state   <= c_st_hunt;
                            r_shift   <= '0;
                            r_gap_cnt <= '0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                        end
                    end else begin
                        r_gap_cnt  <= '0;
                        r_byte_cnt <= r_byte_cnt + 11'd1;
                        case (r_state)
                            c_st_header: begin
                                case (r_byte_cnt)
                                    11'd0:   r_h0  <= in_s.data;
                                    11'd1:   r_h1  <= in_s.data;
                                    11'd6:   r_h6  <= in_s.data[7:3];
                                    11'd7:   r_h7  <= in_s.data[0];
                                    11'd14:  r_h14 <= in_s.data;
                                    11'd15:  r_h15 <= in_s.data;
                                    default: ;
                                endcase
                                if (r_byte_cnt == c_hdr_last) begin
                                    r_state    <= c_st_payload;
                                    r_byte_cnt <= '0;
                                    r_hdr_pend <= 1'b1;
                                end
                            end
                            c_st_payload: begin
                                // Bytes beyond the effective length are fill
                                if (w_fwd) begin
                                    r_out_valid <= 1'b1;
                                    r_out_data  <= in_s.data;
                                    r_out_last  <= ((r_byte_cnt + 11'd1) == w_eff_len);
                                    r_crc       <= crc_byte(r_crc, in_s.data);
                                end
                                if (r_byte_cnt == c_pl_last) begin
                                    r_state    <= c_st_crc;
                                    r_byte_cnt <= '0;
                                end
                            end
                            c_st_crc: begin
                                r_rx_crc <= {r_rx_crc[23:0], in_s.data};
                                if (r_byte_cnt == c_crc_last) begin
                                    r_byte_cnt <= '0;
                                    r_state    <= (c_par_bytes > 0) ? c_st_parity : c_st_report;
                                end
                            end
                            c_st_parity: begin
                                if (r_byte_cnt == c_par_last) begin
                                    r_byte_cnt <= '0;
                                    r_state    <= c_st_report;
                                end
                            end
                            default: r_state <= c_st_hunt;
                        endcase
                    end
                end
            endcase
        end
    end

    assign out_s.valid    = r_out_valid;
    assign out_s.data     = r_out_data;
    assign out_last       = r_out_last;
    assign hdr_valid      = r_hdr_valid;
    assign rx_txfn        = r_rx_txfn;
    assign rx_frame_type  = r_rx_frame_type;
    assign rx_pl_rate     = r_rx_pl_rate;
    assign rx_payload_len = r_rx_payload_len;
    assign frame_ok       = r_frame_ok;
    assign crc_err        = r_crc_err;
    assign len_err        = r_len_err;
    assign frame_abort    = r_frame_abort;
    assign ok_cnt         = r_ok_cnt;
    assign err_cnt        = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_deframer
// Brief    : Directed self-checking bench for deframer (PL_RATE 0 and 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_deframer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    deframer_if #(.DATA_WIDTH(8)) in0 ();
    deframer_if #(.DATA_WIDTH(8)) out0 ();
    deframer_if #(.DATA_WIDTH(8)) in1 ();
    deframer_if #(.DATA_WIDTH(8)) out1 ();

    logic        ol [2];
    logic        hv [2];
    logic        fo [2];
    logic        ce [2];
    logic        le [2];
    logic        fa [2];
    logic [15:0] txfn [2];
    logic [1:0]  ftype [2];
    logic [3:0]  plr [2];
    logic [15:0] plen [2];
    logic [15:0] okc [2];
    logic [15:0] errc [2];
    logic        ov [2];
    logic [7:0]  od [2];

    assign ov[0] = out0.valid;
    assign od[0] = out0.data;
    assign ov[1] = out1.valid;
    assign od[1] = out1.data;

    deframer #(.PL_RATE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_s(in0), .out_s(out0),
        .out_last(ol[0]), .hdr_valid(hv[0]), .rx_txfn(txfn[0]),
        .rx_frame_type(ftype[0]), .rx_pl_rate(plr[0]), .rx_payload_len(plen[0]),
        .frame_ok(fo[0]), .crc_err(ce[0]), .len_err(le[0]), .frame_abort(fa[0]),
        .ok_cnt(okc[0]), .err_cnt(errc[0])
    );

    deframer #(.PL_RATE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_s(in1), .out_s(out1),
        .out_last(ol[1]), .hdr_valid(hv[1]), .rx_txfn(txfn[1]),
        .rx_frame_type(ftype[1]), .rx_pl_rate(plr[1]), .rx_payload_len(plen[1]),
        .frame_ok(fo[1]), .crc_err(ce[1]), .len_err(le[1]), .frame_abort(fa[1]),
        .ok_cnt(okc[1]), .err_cnt(errc[1])
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] exp_pl [2][1052];
    int nout [2], nlast [2], nhdr [2], nok [2], ncrc [2], nab [2], derr [2], idx [2];
    logic [7:0] last_d [2];
    int clr_req  = 0;
    int clr_seen = 0;

    // Output monitor: per-frame event counts and payload comparison against exp_pl
    always @(negedge clk) begin
        if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            for (int s = 0; s < 2; s++) begin
                nout[s] = 0; nlast[s] = 0; nhdr[s] = 0; nok[s] = 0;
                ncrc[s] = 0; nab[s] = 0; derr[s] = 0; idx[s] = 0; last_d[s] = 8'h00;
            end
        end
        for (int s = 0; s < 2; s++) begin
            if (hv[s]) begin nhdr[s]++; idx[s] = 0; end
            if (ov[s]) begin
                if (idx[s] >= 1052) derr[s]++;
                else if (od[s] !== exp_pl[s][idx[s]]) derr[s]++;
                if (ol[s]) last_d[s] = od[s];
                idx[s]++;
                nout[s]++;
            end
            if (ol[s]) nlast[s]++;
            if (fo[s]) nok[s]++;
            if (ce[s]) ncrc[s]++;
            if (fa[s]) nab[s]++;
        end
    end

    task automatic clear_mon();
        clr_req++;
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic v, input logic [7:0] d);
        @(posedge clk);
        #1;
        if (s == 0) begin in0.valid = v; in0.data = d; end
        else        begin in1.valid = v; in1.data = d; end
    endtask

    task automatic idle(input int s, input int n);
        for (int i = 0; i < n; i++) drive(s, 1'b0, 8'h00);
    endtask

    task automatic fill(input int s, input int mode);
        logic [7:0] ref9 [9];
        ref9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        for (int i = 0; i < 1052; i++) begin
            if (mode == 0) exp_pl[s][i] = (i < 9) ? ref9[i] : 8'($urandom);
            else           exp_pl[s][i] = 8'(i * 13 + 5);
        end
    endtask

    function automatic logic [31:0] calc_crc(input int s, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, exp_pl[s][i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic send_frame(input int s, input logic [15:0] tx, input logic [1:0] ft,
                              input logic [3:0] pr, input logic [15:0] len, input logic [31:0] crc,
                              input int npar, input int gap_at, input int gap_len,
                              input bit stop, input bit pre);
        logic [63:0] p;
        logic [7:0]  h;
        p = 64'h53225B1D0D73DF03;
        if (pre) for (int i = 0; i < 8; i++) drive(s, 1'b1, p[63-8*i -: 8]);
        for (int i = 0; i < 120; i++) begin
            case (i)
                0:       h = tx[7:0];
                1:       h = tx[15:8];
                6:       h = {ft[1], pr, 3'b101};
                7:       h = {7'b1010101, ft[0]};
                14:      h = len[15:8];
                15:      h = len[7:0];
                default: h = 8'(i);
            endcase
            drive(s, 1'b1, h);
        end
        for (int i = 0; i < 1052; i++) begin
            if (i == gap_at) begin
                idle(s, gap_len);
                if (stop) return;
            end
            drive(s, 1'b1, exp_pl[s][i]);
        end
        for (int i = 0; i < 4; i++) drive(s, 1'b1, crc[31-8*i -: 8]);
        for (int i = 0; i < npar; i++) drive(s, 1'b1, 8'($urandom));
        drive(s, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++; if (ov[0] !== 1'b0) $display("FAIL rst_out_valid: got %b exp 0", ov[0]); else n_pass++;
        n_chk++; if (ol[0] !== 1'b0) $display("FAIL rst_out_last: got %b exp 0", ol[0]); else n_pass++;
        n_chk++; if ({hv[0], fo[0], ce[0], le[0], fa[0]} !== 5'b0) $display("FAIL rst_flags: got %b exp 00000", {hv[0], fo[0], ce[0], le[0], fa[0]}); else n_pass++;
        n_chk++; if (okc[0] !== 16'd0) $display("FAIL rst_ok_cnt: got %0d exp 0", okc[0]); else n_pass++;
        n_chk++; if (errc[0] !== 16'd0) $display("FAIL rst_err_cnt: got %0d exp 0", errc[0]); else n_pass++;
        n_chk++; if ({txfn[0], plen[0], ftype[0], plr[0]} !== 38'd0) $display("FAIL rst_fields: got %h exp 0", {txfn[0], plen[0], ftype[0], plr[0]}); else n_pass++;
        n_chk++; if ({ov[1], fo[1], okc[1]} !== 18'd0) $display("FAIL rst_dut1: got %h exp 0", {ov[1], fo[1], okc[1]}); else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(0, 2);
    endtask

    task automatic test_good_frame();
        clear_mon();
        fill(0, 0);
        send_frame(0, 16'h1234, 2'd2, 4'd0, 16'd9, 32'h340BC6D9, 0, -1, 0, 1'b0, 1'b1);
        idle(0, 4);
        n_chk++; if (nhdr[0] !== 1) $display("FAIL good_hdr_cnt: got %0d exp 1", nhdr[0]); else n_pass++;
        n_chk++; if (txfn[0] !== 16'h1234) $display("FAIL good_txfn: got %h exp 1234", txfn[0]); else n_pass++;
        n_chk++; if (ftype[0] !== 2'd2) $display("FAIL good_ftype: got %0d exp 2", ftype[0]); else n_pass++;
        n_chk++; if (plen[0] !== 16'd9) $display("FAIL good_len: got %0d exp 9", plen[0]); else n_pass++;
        n_chk++; if (le[0] !== 1'b0) $display("FAIL good_len_err: got %b exp 0", le[0]); else n_pass++;
        n_chk++; if (nout[0] !== 9) $display("FAIL good_nout: got %0d exp 9", nout[0]); else n_pass++;
        n_chk++; if (derr[0] !== 0) $display("FAIL good_data: got %0d bad bytes exp 0", derr[0]); else n_pass++;
        n_chk++; if (nlast[0] !== 1 || last_d[0] !== 8'h39) $display("FAIL good_last: got %0d/%h exp 1/39", nlast[0], last_d[0]); else n_pass++;
        n_chk++; if (nok[0] !== 1 || ncrc[0] !== 0) $display("FAIL good_status: got ok=%0d err=%0d exp 1/0", nok[0], ncrc[0]); else n_pass++;
        n_chk++; if (okc[0] !== 16'd1 || errc[0] !== 16'd0) $display("FAIL good_cnts: got %0d/%0d exp 1/0", okc[0], errc[0]); else n_pass++;
    endtask

    task automatic test_crc_err();
        clear_mon();
        fill(0, 0);
        send_frame(0, 16'h1234, 2'd2, 4'd0, 16'd9, 32'h340BC6D8, 0, -1, 0, 1'b0, 1'b1);
        idle(0, 4);
        n_chk++; if (ncrc[0] !== 1 || nok[0] !== 0) $display("FAIL crc_status: got err=%0d ok=%0d exp 1/0", ncrc[0], nok[0]); else n_pass++;
        n_chk++; if (errc[0] !== 16'd1 || okc[0] !== 16'd1) $display("FAIL crc_cnts: got err=%0d ok=%0d exp 1/1", errc[0], okc[0]); else n_pass++;
        n_chk++; if (nout[0] !== 9 || derr[0] !== 0) $display("FAIL crc_fwd: got %0d bytes %0d bad exp 9/0", nout[0], derr[0]); else n_pass++;
    endtask

    task automatic test_hunt_gap();
        logic [63:0] p;
        p = 64'h53225B1D0D73DF03;
        clear_mon();
        fill(0, 1);
        for (int i = 0; i < 10; i++) drive(0, 1'b1, 8'($urandom));
        for (int i = 0; i < 4; i++) drive(0, 1'b1, p[63-8*i -: 8]);
        idle(0, 3);
        for (int i = 4; i < 8; i++) drive(0, 1'b1, p[63-8*i -: 8]);
        send_frame(0, 16'hBEEF, 2'd1, 4'd0, 16'd5, calc_crc(0, 5), 0, -1, 0, 1'b0, 1'b0);
        idle(0, 4);
        n_chk++; if (nhdr[0] !== 1 || txfn[0] !== 16'hBEEF) $display("FAIL hunt_hdr: got %0d/%h exp 1/beef", nhdr[0], txfn[0]); else n_pass++;
        n_chk++; if (ftype[0] !== 2'd1) $display("FAIL hunt_ftype: got %0d exp 1", ftype[0]); else n_pass++;
        n_chk++; if (nok[0] !== 1 || okc[0] !== 16'd2) $display("FAIL hunt_ok: got %0d/%0d exp 1/2", nok[0], okc[0]); else n_pass++;
        n_chk++; if (nout[0] !== 5 || derr[0] !== 0) $display("FAIL hunt_fwd: got %0d/%0d exp 5/0", nout[0], derr[0]); else n_pass++;
    endtask

    task automatic test_abort();
        clear_mon();
        fill(0, 1);
        send_frame(0, 16'h0001, 2'd0, 4'd0, 16'd600, 32'h0, 0, 500, 16, 1'b1, 1'b1);
        idle(0, 3);
        n_chk++; if (nab[0] !== 1) $display("FAIL abort_pulse: got %0d exp 1", nab[0]); else n_pass++;
        n_chk++; if (errc[0] !== 16'd2) $display("FAIL abort_err_cnt: got %0d exp 2", errc[0]); else n_pass++;
        n_chk++; if (nout[0] !== 500 || nlast[0] !== 0) $display("FAIL abort_fwd: got %0d last=%0d exp 500/0", nout[0], nlast[0]); else n_pass++;
        n_chk++; if (nok[0] !== 0 || ncrc[0] !== 0) $display("FAIL abort_status: got %0d/%0d exp 0/0", nok[0], ncrc[0]); else n_pass++;
        // Follow-up frame carries a 15-cycle gap, one short of the timeout
        clear_mon();
        send_frame(0, 16'h0002, 2'd0, 4'd0, 16'd600, calc_crc(0, 600), 0, 200, 15, 1'b0, 1'b1);
        idle(0, 4);
        n_chk++; if (nab[0] !== 0) $display("FAIL gap15_abort: got %0d exp 0", nab[0]); else n_pass++;
        n_chk++; if (nok[0] !== 1 || okc[0] !== 16'd3) $display("FAIL gap15_ok: got %0d/%0d exp 1/3", nok[0], okc[0]); else n_pass++;
        n_chk++; if (nout[0] !== 600 || derr[0] !== 0) $display("FAIL gap15_fwd: got %0d/%0d exp 600/0", nout[0], derr[0]); else n_pass++;
        n_chk++; if (nlast[0] !== 1 || last_d[0] !== exp_pl[0][599]) $display("FAIL gap15_last: got %0d/%h exp 1/%h", nlast[0], last_d[0], exp_pl[0][599]); else n_pass++;
    endtask

    task automatic test_parity();
        clear_mon();
        fill(1, 1);
        send_frame(1, 16'h5A5A, 2'd3, 4'd1, 16'd0, 32'hFFFFFFFF, 287, -1, 0, 1'b0, 1'b1);
        idle(1, 5);
        n_chk++; if (nok[1] !== 0 || ncrc[1] !== 0) $display("FAIL par_early: got %0d/%0d exp 0/0", nok[1], ncrc[1]); else n_pass++;
        n_chk++; if (nhdr[1] !== 1 || plr[1] !== 4'd1 || ftype[1] !== 2'd3) $display("FAIL par_hdr: got %0d/%0d/%0d exp 1/1/3", nhdr[1], plr[1], ftype[1]); else n_pass++;
        drive(1, 1'b1, 8'hA5);
        idle(1, 4);
        n_chk++; if (nok[1] !== 1 || ncrc[1] !== 0) $display("FAIL par_ok: got %0d/%0d exp 1/0", nok[1], ncrc[1]); else n_pass++;
        n_chk++; if (nout[1] !== 0 || nlast[1] !== 0) $display("FAIL par_nout: got %0d/%0d exp 0/0", nout[1], nlast[1]); else n_pass++;
        n_chk++; if (okc[1] !== 16'd1 || errc[1] !== 16'd0) $display("FAIL par_cnts: got %0d/%0d exp 1/0", okc[1], errc[1]); else n_pass++;
    endtask

    task automatic test_len_err();
        clear_mon();
        fill(0, 1);
        send_frame(0, 16'h7777, 2'd0, 4'd0, 16'd2000, calc_crc(0, 1052), 0, -1, 0, 1'b0, 1'b1);
        idle(0, 4);
        n_chk++; if (le[0] !== 1'b1 || plen[0] !== 16'd2000) $display("FAIL lenerr_flag: got %b/%0d exp 1/2000", le[0], plen[0]); else n_pass++;
        n_chk++; if (nout[0] !== 1052 || derr[0] !== 0) $display("FAIL lenerr_fwd: got %0d/%0d exp 1052/0", nout[0], derr[0]); else n_pass++;
        n_chk++; if (nlast[0] !== 1 || last_d[0] !== exp_pl[0][1051]) $display("FAIL lenerr_last: got %0d/%h exp 1/%h", nlast[0], last_d[0], exp_pl[0][1051]); else n_pass++;
        n_chk++; if (nok[0] !== 1 || okc[0] !== 16'd4) $display("FAIL lenerr_ok: got %0d/%0d exp 1/4", nok[0], okc[0]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        clear_mon();
        fill(0, 1);
        send_frame(0, 16'h0003, 2'd0, 4'd0, 16'd100, 32'h0, 0, 300, 2, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (okc[0] !== 16'd0 || errc[0] !== 16'd0) $display("FAIL midrst_cnts: got %0d/%0d exp 0/0", okc[0], errc[0]); else n_pass++;
        n_chk++; if (le[0] !== 1'b0 || plen[0] !== 16'd0) $display("FAIL midrst_fields: got %b/%0d exp 0/0", le[0], plen[0]); else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_mon();
        fill(0, 0);
        send_frame(0, 16'h1234, 2'd2, 4'd0, 16'd9, 32'h340BC6D9, 0, -1, 0, 1'b0, 1'b1);
        idle(0, 4);
        n_chk++; if (nok[0] !== 1 || okc[0] !== 16'd1) $display("FAIL midrst_recover: got %0d/%0d exp 1/1", nok[0], okc[0]); else n_pass++;
    endtask

    initial begin
        rst_n     = 1'b0;
        in0.valid = 1'b0;
        in0.data  = 8'h00;
        in1.valid = 1'b0;
        in1.data  = 8'h00;
        test_reset();
        test_good_frame();
        test_crc_err();
        test_hunt_gap();
        test_abort();
        test_parity();
        test_len_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
